// File: rtl/alu_op_sequencer.sv
// Issues one command at a time to a combinational ALU through registered operands,
// captures the result and returns it as a tagged response with accumulator chaining and sticky status.
module alu_op_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic                  cmd_chain,
  input  logic [TAG_WIDTH-1:0]  cmd_tag,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_overflow,
  output logic                  rsp_err,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  input  logic                  acc_clr,
  input  logic                  stat_clr,
  output logic                  sticky_ovf,
  output logic [CNT_WIDTH-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RESP} state_t;

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]            alu_op_q, alu_op_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_zero_q, rsp_zero_d;
  logic                  rsp_overflow_q, rsp_overflow_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  sticky_ovf_q, sticky_ovf_d;
  logic [CNT_WIDTH-1:0]  op_count_q, op_count_d;

  logic accept;
  logic rsp_hs;

  assign accept = cmd_valid & cmd_ready_q;
  assign rsp_hs = rsp_valid_q & rsp_ready;

  always_comb begin
    state_d        = state_q;
    cmd_ready_d    = cmd_ready_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_err_d      = rsp_err_q;
    rsp_tag_d      = rsp_tag_q;
    acc_d          = acc_q;
    sticky_ovf_d   = sticky_ovf_q;
    op_count_d     = op_count_q;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          rsp_tag_d   = cmd_tag;
          if (cmd_op <= 3'd4) begin
            // The chained operand reads acc_q, so a same-cycle acc_clr cannot affect it
            alu_a_d = cmd_chain ? acc_q : cmd_a;
            alu_b_d = cmd_b;
            alu_op_d = cmd_op;
            state_d = DRIVE;
          end else begin
            rsp_result_d   = '0;
            rsp_zero_d     = 1'b0;
            rsp_overflow_d = 1'b0;
            rsp_err_d      = 1'b1;
            rsp_valid_d    = 1'b1;
            state_d        = RESP;
          end
        end
      end
      DRIVE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rsp_result_d   = alu_result;
        rsp_zero_d     = alu_zero;
        rsp_overflow_d = alu_overflow;
        rsp_err_d      = 1'b0;
        rsp_valid_d    = 1'b1;
        acc_d          = alu_result;
        state_d        = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase

    if (acc_clr) begin
      acc_d = '0;
    end

    if (rsp_hs) begin
      op_count_d = op_count_q + CNT_WIDTH'(1);
      if (rsp_overflow_q) begin
        sticky_ovf_d = 1'b1;
      end
    end
    if (stat_clr) begin
      op_count_d   = '0;
      sticky_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cmd_ready_q    <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_tag_q      <= '0;
      acc_q          <= '0;
      sticky_ovf_q   <= 1'b0;
      op_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      cmd_ready_q    <= cmd_ready_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_err_q      <= rsp_err_d;
      rsp_tag_q      <= rsp_tag_d;
      acc_q          <= acc_d;
      sticky_ovf_q   <= sticky_ovf_d;
      op_count_q     <= op_count_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_tag      = rsp_tag_q;
  assign sticky_ovf   = sticky_ovf_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: a behavioural ALU closes the loop, and an arithmetic
// reference model predicts every response, latency, accumulator and status value.
module tb_alu_op_sequencer;

  localparam int DW = 32;
  localparam int TW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic          cmd_chain;
  logic [TW-1:0] cmd_tag;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic          alu_overflow;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero;
  logic          rsp_overflow;
  logic          rsp_err;
  logic [TW-1:0] rsp_tag;
  logic          acc_clr;
  logic          stat_clr;
  logic          sticky_ovf;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .DATA_WIDTH(DW),
    .TAG_WIDTH (TW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_chain   (cmd_chain),
    .cmd_tag     (cmd_tag),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .alu_overflow(alu_overflow),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_overflow(rsp_overflow),
    .rsp_err     (rsp_err),
    .rsp_tag     (rsp_tag),
    .acc_clr     (acc_clr),
    .stat_clr    (stat_clr),
    .sticky_ovf  (sticky_ovf),
    .op_count    (op_count)
  );

  // Combinational ALU the sequencer talks to
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'd0: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[DW-1] == alu_b[DW-1]) && (alu_result[DW-1] != alu_a[DW-1]);
      end
      3'd1: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[DW-1] != alu_b[DW-1]) && (alu_result[DW-1] != alu_a[DW-1]);
      end
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] accM;
  logic [DW-1:0] lastA;
  logic [DW-1:0] lastB;
  logic [2:0]    lastOp;
  int            countM;
  logic          stickyM;

  logic [2:0]    rOp;
  logic [DW-1:0] rA;
  logic [DW-1:0] rB;
  logic          rChain;
  logic          rClr;
  int            rHold;

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Reference semantics from signed integer arithmetic
  task automatic refModel(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output logic [DW-1:0] r, output logic z, output logic o, output logic e);
    longint sa;
    longint sb;
    longint wide;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    wide = 0;
    e    = 1'b0;
    case (op)
      3'd0: begin wide = sa + sb; r = a + b; end
      3'd1: begin wide = sa - sb; r = a - b; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: begin r = '0; e = 1'b1; end
    endcase
    o = (op <= 3'd1) && ((wide > 64'sd2147483647) || (wide < -64'sd2147483648));
    z = !e && (r == '0);
  endtask

  task automatic checkRsp(input string ctx, input logic [DW-1:0] er, input logic ez, input logic eo,
                          input logic ee, input logic [TW-1:0] et);
    checkOutput({ctx, "_valid"}, rsp_valid, 1);
    checkOutput({ctx, "_result"}, rsp_result, er);
    checkOutput({ctx, "_zero"}, rsp_zero, ez);
    checkOutput({ctx, "_ovf"}, rsp_overflow, eo);
    checkOutput({ctx, "_err"}, rsp_err, ee);
    checkOutput({ctx, "_tag"}, rsp_tag, et);
    checkOutput({ctx, "_cmd_ready"}, cmd_ready, 0);
  endtask

  // One full command: issue, check operands and latency, optionally stall, then hand off
  task automatic applyStimulus(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic chain, input logic [TW-1:0] tag, input int hold,
                               input logic clrAtAccept);
    logic [DW-1:0] opA;
    logic [DW-1:0] er;
    logic          ez;
    logic          eo;
    logic          ee;
    int            cycles;
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    opA = chain ? accM : a;
    refModel(op, opA, b, er, ez, eo, ee);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_chain = chain;
    cmd_tag   = tag;
    acc_clr   = clrAtAccept;
    stepClk();
    cmd_valid = 1'b0;
    acc_clr   = 1'b0;
    if (clrAtAccept) accM = '0;
    if (!ee) begin
      lastA  = opA;
      lastB  = b;
      lastOp = op;
      accM   = er;
    end
    checkOutput("alu_a", alu_a, lastA);
    checkOutput("alu_b", alu_b, lastB);
    checkOutput("alu_op", alu_op, lastOp);
    cycles = 1;
    while (!rsp_valid && cycles < 10) begin
      checkOutput("busy_cmd_ready", cmd_ready, 0);
      stepClk();
      cycles++;
    end
    checkOutput("rsp_latency", cycles, ee ? 1 : 3);
    for (int h = 0; h < hold; h++) begin
      checkRsp("hold", er, ez, eo, ee, tag);
      stepClk();
    end
    checkRsp("rsp", er, ez, eo, ee, tag);
    rsp_ready = 1'b1;
    stepClk();
    rsp_ready = 1'b0;
    countM = (countM + 1) % (1 << CW);
    if (eo) stickyM = 1'b1;
    checkOutput("post_rsp_valid", rsp_valid, 0);
    checkOutput("post_cmd_ready", cmd_ready, 1);
    checkOutput("op_count", op_count, countM);
    checkOutput("sticky_ovf", sticky_ovf, stickyM);
  endtask

  task automatic pulseAccClr();
    acc_clr = 1'b1;
    stepClk();
    acc_clr = 1'b0;
    accM = '0;
  endtask

  task automatic pulseStatClr();
    stat_clr = 1'b1;
    stepClk();
    stat_clr = 1'b0;
    countM  = 0;
    stickyM = 1'b0;
    checkOutput("stat_clr_count", op_count, 0);
    checkOutput("stat_clr_sticky", sticky_ovf, 0);
  endtask

  task automatic checkAllZero(input string ctx);
    checkOutput({ctx, "_cmd_ready"}, cmd_ready, 0);
    checkOutput({ctx, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({ctx, "_alu_a"}, alu_a, 0);
    checkOutput({ctx, "_alu_b"}, alu_b, 0);
    checkOutput({ctx, "_alu_op"}, alu_op, 0);
    checkOutput({ctx, "_rsp_result"}, rsp_result, 0);
    checkOutput({ctx, "_rsp_flags"}, {rsp_zero, rsp_overflow, rsp_err}, 0);
    checkOutput({ctx, "_rsp_tag"}, rsp_tag, 0);
    checkOutput({ctx, "_sticky"}, sticky_ovf, 0);
    checkOutput({ctx, "_count"}, op_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_chain = 1'b0;
    cmd_tag   = '0;
    rsp_ready = 1'b0;
    acc_clr   = 1'b0;
    stat_clr  = 1'b0;
    accM      = '0;
    lastA     = '0;
    lastB     = '0;
    lastOp    = '0;
    countM    = 0;
    stickyM   = 1'b0;

    #2;
    checkAllZero("reset");
    stepClk();
    checkAllZero("reset_edge");
    rst_n = 1'b1;
    stepClk();
    checkOutput("ready_after_reset", cmd_ready, 1);

    applyStimulus(3'd0, 32'd5, 32'd7, 1'b0, 4'd3, 0, 1'b0);
    checkOutput("add_count_one", op_count, 1);
    applyStimulus(3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd4, 0, 1'b0);
    checkOutput("sub_sticky_set", sticky_ovf, 1);
    applyStimulus(3'd1, 32'd9, 32'd9, 1'b0, 4'd5, 0, 1'b0);

    applyStimulus(3'd0, 32'd10, 32'd0, 1'b0, 4'd6, 0, 1'b0);
    applyStimulus(3'd0, 32'hDEAD_BEEF, 32'd5, 1'b1, 4'd7, 0, 1'b0);
    checkOutput("chain_15", rsp_result, 15);
    pulseAccClr();
    applyStimulus(3'd0, 32'hDEAD_BEEF, 32'd1, 1'b1, 4'd8, 0, 1'b0);
    checkOutput("chain_after_clr", rsp_result, 1);

    applyStimulus(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 4'd9, 0, 1'b0);
    applyStimulus(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 4'd10, 5, 1'b0);
    applyStimulus(3'd0, 32'd0, 32'd100, 1'b1, 4'd11, 0, 1'b1);

    pulseStatClr();

    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_a     = 32'd20;
    cmd_b     = 32'd22;
    cmd_chain = 1'b0;
    cmd_tag   = 4'd12;
    stepClk();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkAllZero("midop_reset");
    accM    = '0;
    lastA   = '0;
    lastB   = '0;
    lastOp  = '0;
    countM  = 0;
    stickyM = 1'b0;
    stepClk();
    rst_n = 1'b1;
    stepClk();
    checkOutput("ready_after_midop", cmd_ready, 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("no_stale_rsp", rsp_valid, 0);
      stepClk();
    end
    applyStimulus(3'd0, 32'd20, 32'd22, 1'b0, 4'd13, 0, 1'b0);
    applyStimulus(3'd4, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1, 4'd14, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rOp    = 3'($urandom_range(0, 7));
      rA     = $urandom;
      rB     = ($urandom_range(0, 4) == 0) ? rA : $urandom;
      rChain = ($urandom_range(0, 2) == 0);
      rClr   = ($urandom_range(0, 5) == 0);
      rHold  = $urandom_range(0, 2);
      if (rChain) rB = ($urandom_range(0, 3) == 0) ? accM : rB;
      applyStimulus(rOp, rA, rB, rChain, 4'($urandom_range(0, 15)), rHold, rClr);
      if ($urandom_range(0, 9) == 0) pulseStatClr();
      if ($urandom_range(0, 9) == 0) pulseAccClr();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
